// File: rtl/multicycle_controller.sv
// Sequencing controller for the multi-cycle MIPS datapath.
// Walks each instruction through fetch, decode, execute, memory and write-back
// steps, drives every datapath select/enable from the current state, owns the
// shared-memory request handshake and stops the core on illegal instructions or
// on a memory that never answers.
module multicycle_controller #(
    parameter int MEM_WAIT_MAX = 15,
    parameter bit HALT_ON_ILL  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_ctl,
    output logic       instr_done,
    output logic       halted,
    output logic [1:0] err,
    output logic [3:0] state
);

    // Instruction encodings
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    // ALU control codes
    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;

    // Legal R-type functs and the ALU code each one selects, entry by entry
    localparam int         N_RFN     = 5;
    localparam logic [29:0] R_FUNCTS = {6'h2A, 6'h25, 6'h24, 6'h22, 6'h20};
    localparam logic [19:0] R_CODES  = {ALU_SLT, ALU_OR, ALU_AND, ALU_SUB, ALU_ADD};

    // Error codes
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    // Stall counter sized to hold the timeout limit
    localparam int                WAIT_W    = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_WB_ALU   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    state_t            state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [1:0]        err_reg, err_next;

    // ------------------------------------------------------------------
    // Instruction decode (IR is stable from DECODE until the next fetch)
    // ------------------------------------------------------------------
    logic [N_RFN-1:0]   r_hit;
    logic [4*N_RFN-1:0] r_alu_terms;
    logic [3:0]         r_alu_ctl;
    logic               is_rtype, r_legal, is_jr, is_lw, is_sw, is_addi;
    logic               is_branch, is_jimm, is_jal, decode_illegal;

    genvar gi;
    generate
        for (gi = 0; gi < N_RFN; gi++) begin : g_rfunct
            assign r_hit[gi]               = (funct == R_FUNCTS[gi*6 +: 6]);
            assign r_alu_terms[gi*4 +: 4] = r_hit[gi] ? R_CODES[gi*4 +: 4] : 4'd0;
        end
    endgenerate

    // Merge the per-funct ALU codes; at most one entry can be hit
    always_comb begin
        r_alu_ctl = 4'd0;
        for (int i = 0; i < N_RFN; i++) begin
            r_alu_ctl = r_alu_ctl | r_alu_terms[i*4 +: 4];
        end
    end

    assign is_rtype       = (opcode == OP_RTYPE);
    assign r_legal        = is_rtype && (|r_hit);
    assign is_jr          = is_rtype && (funct == FN_JR);
    assign is_lw          = (opcode == OP_LW);
    assign is_sw          = (opcode == OP_SW);
    assign is_addi        = (opcode == OP_ADDI);
    assign is_branch      = (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign is_jal         = (opcode == OP_JAL);
    assign is_jimm        = (opcode == OP_J) || is_jal;
    assign decode_illegal = !(r_legal || is_jr || is_lw || is_sw || is_addi ||
                              is_branch || is_jimm);

    // ------------------------------------------------------------------
    // Memory handshake bookkeeping
    // ------------------------------------------------------------------
    logic mem_phase, mem_stall, mem_timeout;

    assign mem_phase   = (state_reg == S_FETCH) || (state_reg == S_MEM_RD) ||
                         (state_reg == S_MEM_WR);
    assign mem_stall   = mem_phase && !mem_ready;
    // The stall that would bring the count to the limit is the last one tolerated;
    // a mem_ready arriving in that same cycle clears mem_stall and wins.
    assign mem_timeout = mem_stall && (wait_cnt_reg == WAIT_LAST);

    // State, stall counter and sticky error register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_FETCH;
            wait_cnt_reg <= '0;
            err_reg      <= ERR_NONE;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            err_reg      <= err_next;
        end
    end

    // Next-state selection, stall counting and error capture
    always_comb begin
        state_next    = state_reg;
        err_next      = err_reg;
        wait_cnt_next = '0;
        if (mem_stall) begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
        end

        case (state_reg)
            S_FETCH: begin
                if (mem_ready) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (r_legal) begin
                    state_next = S_EXEC_R;
                end else if (is_jr) begin
                    state_next = S_JUMP;
                end else if (is_lw || is_sw) begin
                    state_next = S_MEM_ADDR;
                end else if (is_addi) begin
                    state_next = S_EXEC_I;
                end else if (is_branch) begin
                    state_next = S_BRANCH;
                end else if (is_jimm) begin
                    state_next = S_JUMP;
                end else if (HALT_ON_ILL) begin
                    state_next = S_HALT;
                    err_next   = ERR_ILLEGAL;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_EXEC_R:   state_next = S_WB_ALU;
            S_EXEC_I:   state_next = S_WB_ALU;
            S_WB_ALU:   state_next = S_FETCH;
            S_MEM_ADDR: state_next = is_lw ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready) begin
                    state_next = S_WB_MEM;
                end
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_next = S_FETCH;
                end
            end
            S_WB_MEM:   state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_JUMP:     state_next = S_FETCH;
            S_HALT:     state_next = S_HALT;
            default:    state_next = S_FETCH;
        endcase

        if (mem_timeout) begin
            state_next    = S_HALT;
            err_next      = ERR_TIMEOUT;
            wait_cnt_next = '0;
        end
    end

    // Datapath controls decoded from the current state; everything is forced low in reset
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        reg_write  = 1'b0;
        reg_dst    = 2'd0;
        mem_to_reg = 2'd0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_ctl    = ALU_AND;
        instr_done = 1'b0;
        halted     = 1'b0;
        err        = err_reg;
        state      = state_reg;

        case (state_reg)
            S_FETCH: begin
                // PC+4 computed alongside the instruction read; both latch on ready,
                // so a stalled (or timing-out) fetch writes nothing.
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                alu_ctl   = ALU_ADD;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut
                alu_src_b = 2'd3;
                alu_ctl   = ALU_ADD;
                if (decode_illegal && !HALT_ON_ILL) begin
                    instr_done = 1'b1;
                end
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_ctl   = r_alu_ctl;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_ctl   = ALU_ADD;
            end
            S_WB_ALU: begin
                reg_write  = 1'b1;
                reg_dst    = is_rtype ? 2'd1 : 2'd0;
                instr_done = 1'b1;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEM_WR: begin
                mem_req    = 1'b1;
                iord       = 1'b1;
                mem_we     = 1'b1;
                instr_done = mem_ready;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'd1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_ctl    = ALU_SUB;
                pc_src     = 2'd1;
                pc_write   = (opcode == OP_BNE) ? ~zero : zero;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = is_jr ? 2'd3 : 2'd2;
                instr_done = 1'b1;
                // jal links the already-incremented PC into r31
                if (is_jal) begin
                    reg_write  = 1'b1;
                    reg_dst    = 2'd2;
                    mem_to_reg = 2'd2;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase

        if (reset) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            iord       = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 2'd0;
            reg_write  = 1'b0;
            reg_dst    = 2'd0;
            mem_to_reg = 2'd0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'd0;
            alu_ctl    = 4'd0;
            instr_done = 1'b0;
            halted     = 1'b0;
            err        = 2'd0;
            state      = 4'd0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instruction walks with hand-computed
// expectations, then a randomized instruction/memory-stall/reset stream checked
// every cycle against an instruction-level reference model.
module tb_multicycle_controller;

    localparam int WAIT_MAX = 15;
    localparam bit ILL_HALT = 1'b1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctl;
    logic       instr_done, halted;
    logic [1:0] err;
    logic [3:0] state;

    multicycle_controller #(
        .MEM_WAIT_MAX(WAIT_MAX),
        .HALT_ON_ILL (ILL_HALT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .iord      (iord),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .reg_write (reg_write),
        .reg_dst   (reg_dst),
        .mem_to_reg(mem_to_reg),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_ctl   (alu_ctl),
        .instr_done(instr_done),
        .halted    (halted),
        .err       (err),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_ctl;
        logic       instr_done;
        logic       halted;
        logic [1:0] err;
        logic [3:0] state;
    } outs_t;

    outs_t obs;
    assign obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write, reg_dst,
                  mem_to_reg, alu_src_a, alu_src_b, alu_ctl, instr_done, halted, err, state};

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int want);
        n_vec++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, want);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: an instruction is FETCH, DECODE, then a plan of
    // steps chosen by the decoded instruction; retiring = finishing the plan.
    // ------------------------------------------------------------------
    typedef enum int {K_FETCH, K_DECODE, K_EXR, K_EXI, K_WBALU, K_ADDR,
                      K_RD, K_WR, K_WBMEM, K_BR, K_JMP} kind_t;

    kind_t      plan [3];
    int         plan_len = 0;
    int         m_idx = 0;
    int         m_stall = 0;
    bit         m_halt = 1'b0;
    bit         m_valid = 1'b0;
    logic [1:0] m_err = 2'd0;

    initial begin : compare_proc
        outs_t      e;
        logic [27:0] got;
        kind_t      k;
        bit         adv, is_mem, n_halt, n_valid;
        int         n_idx, n_stall;
        logic [1:0] n_err_code;
        forever begin
            @(negedge clk);
            e = '0;
            n_idx = m_idx; n_stall = m_stall; n_halt = m_halt;
            n_valid = m_valid; n_err_code = m_err;
            if (reset) begin
                n_valid = 1'b1; n_idx = 0; n_stall = 0; n_halt = 1'b0; n_err_code = 2'd0;
            end else if (m_valid && m_halt) begin
                e.halted = 1'b1;
                e.err    = m_err;
            end else if (m_valid) begin
                e.err  = m_err;
                k      = (m_idx == 0) ? K_FETCH : (m_idx == 1) ? K_DECODE : plan[m_idx-2];
                adv    = 1'b1;
                is_mem = 1'b0;
                case (k)
                    K_FETCH: begin
                        e.mem_req = 1'b1; e.alu_src_b = 2'd1; e.alu_ctl = 4'd2; is_mem = 1'b1;
                        if (mem_ready) begin e.ir_write = 1'b1; e.pc_write = 1'b1; end
                    end
                    K_DECODE: begin
                        e.alu_src_b = 2'd3; e.alu_ctl = 4'd2;
                        plan_len = 0;
                        if (opcode == 6'h00 && (funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A})) begin
                            plan[0] = K_EXR; plan[1] = K_WBALU; plan_len = 2;
                        end else if (opcode == 6'h00 && funct == 6'h08) begin
                            plan[0] = K_JMP; plan_len = 1;
                        end else begin
                            case (opcode)
                                6'h23: begin plan[0] = K_ADDR; plan[1] = K_RD; plan[2] = K_WBMEM; plan_len = 3; end
                                6'h2B: begin plan[0] = K_ADDR; plan[1] = K_WR; plan_len = 2; end
                                6'h08: begin plan[0] = K_EXI; plan[1] = K_WBALU; plan_len = 2; end
                                6'h04, 6'h05: begin plan[0] = K_BR; plan_len = 1; end
                                6'h02, 6'h03: begin plan[0] = K_JMP; plan_len = 1; end
                                default: plan_len = 0;
                            endcase
                        end
                    end
                    K_EXR: begin
                        e.alu_src_a = 1'b1;
                        case (funct)
                            6'h20: e.alu_ctl = 4'd2;
                            6'h22: e.alu_ctl = 4'd6;
                            6'h24: e.alu_ctl = 4'd0;
                            6'h25: e.alu_ctl = 4'd1;
                            default: e.alu_ctl = 4'd7;
                        endcase
                    end
                    K_EXI, K_ADDR: begin
                        e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.alu_ctl = 4'd2;
                    end
                    K_WBALU: begin
                        e.reg_write = 1'b1; e.reg_dst = (opcode == 6'h00) ? 2'd1 : 2'd0;
                    end
                    K_RD: begin e.mem_req = 1'b1; e.iord = 1'b1; is_mem = 1'b1; end
                    K_WR: begin e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = 1'b1; is_mem = 1'b1; end
                    K_WBMEM: begin e.reg_write = 1'b1; e.mem_to_reg = 2'd1; end
                    K_BR: begin
                        e.alu_src_a = 1'b1; e.alu_ctl = 4'd6; e.pc_src = 2'd1;
                        e.pc_write = (opcode == 6'h04) ? zero : !zero;
                    end
                    default: begin
                        e.pc_write = 1'b1;
                        e.pc_src = (opcode == 6'h00) ? 2'd3 : 2'd2;
                        if (opcode == 6'h03) begin
                            e.reg_write = 1'b1; e.reg_dst = 2'd2; e.mem_to_reg = 2'd2;
                        end
                    end
                endcase
                if (is_mem && !mem_ready) begin
                    adv = 1'b0;
                    n_stall = m_stall + 1;
                    if (n_stall == WAIT_MAX) begin
                        n_halt = 1'b1; n_err_code = 2'd2; n_stall = 0;
                    end
                end
                if (k == K_DECODE && plan_len == 0) begin
                    adv = 1'b0;
                    if (ILL_HALT) begin
                        n_halt = 1'b1; n_err_code = 2'd1;
                    end else begin
                        e.instr_done = 1'b1; n_idx = 0;
                    end
                end
                if (adv) begin
                    n_stall = 0;
                    if (m_idx >= 2 && m_idx == plan_len + 1) begin
                        e.instr_done = 1'b1; n_idx = 0;
                    end else begin
                        n_idx = m_idx + 1;
                    end
                end
            end
            if (reset || m_valid) begin
                got = obs;
                if (!reset) got[3:0] = 4'd0;
                n_vec++;
                if (got !== e) begin
                    n_err++;
                    $display("FAIL cycle_model t=%0t got=%07h required=%07h", $time, got, e);
                end
            end
            @(posedge clk);
            m_idx = n_idx; m_stall = n_stall; m_halt = n_halt;
            m_valid = n_valid; m_err = n_err_code;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    outs_t snap [1:32];

    // Called at posedge+1 with the DUT in FETCH; runs until retire or halt
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input logic [31:0] rdy_mask, input int max_cyc, output int end_cyc);
        end_cyc = 0;
        opcode  = op;
        funct   = fn;
        zero    = z;
        for (int c = 1; c <= max_cyc && end_cyc == 0; c++) begin
            mem_ready = rdy_mask[c-1];
            @(negedge clk);
            snap[c] = obs;
            if (obs.instr_done || obs.halted) end_cyc = c;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("reset_outputs_zero", int'(obs), 0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    task automatic pick_instr(input bit mem_only);
        int sel;
        sel = mem_only ? (6 + int'($urandom_range(0, 1))) : int'($urandom_range(0, 13));
        funct = 6'($urandom);
        case (sel)
            0:  begin opcode = 6'h00; funct = 6'h20; end
            1:  begin opcode = 6'h00; funct = 6'h22; end
            2:  begin opcode = 6'h00; funct = 6'h24; end
            3:  begin opcode = 6'h00; funct = 6'h25; end
            4:  begin opcode = 6'h00; funct = 6'h2A; end
            5:  begin opcode = 6'h00; funct = 6'h08; end
            6:  opcode = 6'h23;
            7:  opcode = 6'h2B;
            8:  opcode = 6'h08;
            9:  opcode = 6'h04;
            10: opcode = 6'h05;
            11: opcode = 6'h02;
            12: opcode = 6'h03;
            default: begin
                if ($urandom_range(0, 1) == 0) begin
                    opcode = 6'h00;
                    do funct = 6'($urandom);
                    while (funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08});
                end else begin
                    do opcode = 6'($urandom);
                    while (opcode inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B});
                end
            end
        endcase
    endtask

    // ------------------------------------------------------------------
    // Directed walks with hand-computed expectations, then random traffic
    // ------------------------------------------------------------------
    initial begin : driver
        int e;
        int halt_wait, mode, since, burst, r;
        bit picked;

        do_reset(2);

        // add: retires on cycle 4, EXEC_R uses ADD, WB_ALU writes rd
        run_instr(6'h00, 6'h20, 1'b0, 32'hFFFF_FFFF, 10, e);
        chk("add_retire_cycle", e, 4);
        chk("add_exec_alu_ctl", int'(snap[3].alu_ctl), 2);
        chk("add_wb_reg_write", int'(snap[4].reg_write), 1);
        chk("add_wb_reg_dst", int'(snap[4].reg_dst), 1);

        // lw with 3 stalled cycles in MEM_RD: retires on cycle 8
        run_instr(6'h23, 6'h00, 1'b0, ~32'h0000_0038, 12, e);
        chk("lw_stall_retire_cycle", e, 8);
        chk("lw_wb_mem_to_reg", int'(snap[8].mem_to_reg), 1);
        chk("lw_wb_reg_dst", int'(snap[8].reg_dst), 0);

        // sw: retires on cycle 4 with a write request
        run_instr(6'h2B, 6'h00, 1'b0, 32'hFFFF_FFFF, 10, e);
        chk("sw_retire_cycle", e, 4);
        chk("sw_mem_we", int'(snap[4].mem_we), 1);

        // beq taken / bne not taken with zero=1
        run_instr(6'h04, 6'h00, 1'b1, 32'hFFFF_FFFF, 10, e);
        chk("beq_retire_cycle", e, 3);
        chk("beq_pc_write", int'(snap[3].pc_write), 1);
        chk("beq_pc_src", int'(snap[3].pc_src), 1);
        run_instr(6'h05, 6'h00, 1'b1, 32'hFFFF_FFFF, 10, e);
        chk("bne_pc_write", int'(snap[3].pc_write), 0);
        chk("bne_instr_done", int'(snap[3].instr_done), 1);

        // jal links r31, jr jumps to rs without writing
        run_instr(6'h03, 6'h15, 1'b0, 32'hFFFF_FFFF, 10, e);
        chk("jal_retire_cycle", e, 3);
        chk("jal_pc_src", int'(snap[3].pc_src), 2);
        chk("jal_reg_dst", int'(snap[3].reg_dst), 2);
        chk("jal_mem_to_reg", int'(snap[3].mem_to_reg), 2);
        chk("jal_reg_write", int'(snap[3].reg_write), 1);
        run_instr(6'h00, 6'h08, 1'b0, 32'hFFFF_FFFF, 10, e);
        chk("jr_pc_src", int'(snap[3].pc_src), 3);
        chk("jr_reg_write", int'(snap[3].reg_write), 0);

        // lw abandoned by a 3-cycle reset while stalled in MEM_RD
        run_instr(6'h23, 6'h00, 1'b0, 32'h0000_0007, 5, e);
        chk("lw_abandon_not_retired", e, 0);
        do_reset(3);
        run_instr(6'h02, 6'h00, 1'b0, 32'hFFFF_FFFF, 10, e);
        chk("post_reset_mem_req", int'(snap[1].mem_req), 1);
        chk("post_reset_iord", int'(snap[1].iord), 0);
        chk("post_reset_j_retire", e, 3);

        // Illegal opcode halts right after DECODE
        run_instr(6'h3F, 6'h00, 1'b0, 32'hFFFF_FFFF, 10, e);
        chk("illegal_halt_cycle", e, 3);
        chk("illegal_err", int'(snap[3].err), 1);
        do_reset(1);

        // Memory stuck low in FETCH: 15 stalls, halted on cycle 16
        run_instr(6'h00, 6'h20, 1'b0, 32'h0000_0000, 20, e);
        chk("timeout_halt_cycle", e, 16);
        chk("timeout_not_early", int'(snap[15].halted), 0);
        chk("timeout_err", int'(snap[16].err), 2);
        do_reset(2);

        // Randomized instruction stream with stalls, timeouts and resets
        halt_wait = 0; picked = 1'b0; mode = 0; since = 0; burst = 15;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (m_halt) begin
                halt_wait++;
                if (halt_wait > 3) begin
                    do_reset(1 + int'($urandom_range(0, 1)));
                    halt_wait = 0;
                    picked = 1'b0;
                end
            end else if ($urandom_range(0, 199) == 0) begin
                do_reset(1 + int'($urandom_range(0, 2)));
                picked = 1'b0;
            end
            if (m_idx != 0) begin
                picked = 1'b0;
            end else if (!picked && !m_halt) begin
                r = int'($urandom_range(0, 99));
                mode  = (r < 85) ? 0 : (r < 90) ? 1 : (r < 94) ? 2 : 3;
                burst = (mode == 1) ? (WAIT_MAX - 1) : WAIT_MAX;
                pick_instr(mode == 3);
                picked = 1'b1;
                since = 0;
            end
            case (mode)
                1, 2: mem_ready = (since < burst) ? 1'b0 :
                                  (since == burst) ? 1'b1 : ($urandom_range(0, 99) < 70);
                3:    mem_ready = (m_idx >= 2) ? 1'b0 : 1'b1;
                default: mem_ready = ($urandom_range(0, 99) < 70);
            endcase
            since++;
            zero = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
